// File: rtl/corr_pkg.sv
// rtl/corr_pkg.sv - shared FSM encoding and width helper for the correlator accumulation scheduler
package corr_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        RUN       = 2'd2
    } state_t;

    // Channel index width; a one-channel vector still needs a 1-bit index
    function automatic int chan_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/corr_frame_checker.sv
// rtl/corr_frame_checker.sv - counts valid samples per frame and flags frames of the wrong length
module corr_frame_checker #(
    parameter int VECTOR_LEN = 64,
    parameter int CNT_W      = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic sync_in,
    input  logic din_valid,
    input  logic clr,
    output logic frame_err
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(VECTOR_LEN);

    logic [CNT_W-1:0] chan_cnt;
    logic             short_or_long;
    logic             overflow;

    // A sync closes the previous frame; a valid beyond a full frame is an overrun
    always_comb begin
        short_or_long = run && sync_in && (chan_cnt != FULL);
        overflow      = run && !sync_in && din_valid && (chan_cnt == FULL);
    end

    // Clear-then-count on sync so a same-cycle sample belongs to the new frame; sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chan_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            if (sync_in) begin
                chan_cnt <= (run && din_valid) ? CNT_W'(1) : '0;
            end else if (run && din_valid && chan_cnt != FULL) begin
                chan_cnt <= chan_cnt + CNT_W'(1);
            end
            if (clr) begin
                frame_err <= 1'b0;
            end else if (short_or_long || overflow) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/corr_acc_scheduler.sv
// rtl/corr_acc_scheduler.sv - new_acc sequencing, frame check and readout indexing; optional CORR_ACC_COUNT_EN adds acc_count
module corr_acc_scheduler
    import corr_pkg::*;
#(
    parameter int VECTOR_LEN = 64,
    parameter int ACC_LEN_W  = 16,
    localparam int CHAN_W    = chan_w(VECTOR_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic [ACC_LEN_W-1:0] acc_len,
    input  logic                 sync_in,
    input  logic                 din_valid,
    input  logic                 corr_valid,
    output logic                 new_acc,
    output logic                 running,
    output logic                 frame_err,
    output logic [CHAN_W-1:0]    rd_chan,
    output logic                 rd_last
`ifdef CORR_ACC_COUNT_EN
    ,
    output logic [31:0]          acc_count
`endif
);

    localparam logic [ACC_LEN_W-1:0] ONE      = ACC_LEN_W'(1);
    localparam logic [CHAN_W-1:0]    LAST_CHAN = CHAN_W'(VECTOR_LEN - 1);

    state_t                state;
    state_t                state_nxt;
    logic [ACC_LEN_W-1:0]  len_q;
    logic [ACC_LEN_W-1:0]  frame_cnt;
    logic [ACC_LEN_W-1:0]  len_eff;
    logic [CHAN_W-1:0]     rd_cnt;
    logic                  last_frame;
    logic                  start;
    logic                  rearm;

    // Integration boundaries and next state; an acc_len of 0 behaves as 1
    always_comb begin
        len_eff    = (acc_len == '0) ? ONE : acc_len;
        last_frame = (frame_cnt == len_q - ONE);
        rearm      = (state == IDLE) && arm;
        start      = ((state == WAIT_SYNC) && arm && sync_in) ||
                     ((state == RUN) && sync_in && last_frame && arm);
        state_nxt  = state;
        case (state)
            IDLE:      if (arm) state_nxt = WAIT_SYNC;
            WAIT_SYNC: if (!arm) state_nxt = IDLE;
                       else if (sync_in) state_nxt = RUN;
            RUN:       if (sync_in && last_frame && !arm) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // FSM state, registered outputs and integration counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            running   <= 1'b0;
            new_acc   <= 1'b0;
            len_q     <= '0;
            frame_cnt <= '0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == RUN);
            new_acc <= start && !new_acc;
            if (start) begin
                len_q     <= len_eff;
                frame_cnt <= '0;
            end else if ((state == RUN) && sync_in) begin
                frame_cnt <= last_frame ? '0 : frame_cnt + ONE;
            end
        end
    end

    // Readout index runs off corr_valid alone so a dump is never mis-indexed by FSM activity
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt <= '0;
        end else if (corr_valid) begin
            rd_cnt <= (rd_cnt == LAST_CHAN) ? '0 : rd_cnt + CHAN_W'(1);
        end
    end

    assign rd_chan = rd_cnt;
    assign rd_last = corr_valid && (rd_cnt == LAST_CHAN);

`ifdef CORR_ACC_COUNT_EN
    // Completed dumps since the last arm
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_count <= '0;
        end else if (rearm) begin
            acc_count <= '0;
        end else if (rd_last) begin
            acc_count <= acc_count + 32'd1;
        end
    end
`endif

    corr_frame_checker #(
        .VECTOR_LEN (VECTOR_LEN),
        .CNT_W      (CHAN_W + 1)
    ) u_frame_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (state == RUN),
        .sync_in   (sync_in),
        .din_valid (din_valid),
        .clr       (rearm),
        .frame_err (frame_err)
    );

endmodule
